inst_fetch_unit: RTL and testbench

//   Read-side master for the 256x8 instruction memory. Owns the PC and drives

---
 rtl/inst_fetch_unit.sv | 134 +++++++++++++
 tb/tb_inst_fetch_unit.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, reads the instruction memory and
// queues fetched words with their PCs in a small prefetch buffer for decode.
module inst_fetch_unit #(
    parameter int unsigned        ADDR_W      = 8,
    parameter int unsigned        DATA_W      = 8,
    parameter int unsigned        BUF_DEPTH   = 2,
    parameter logic [ADDR_W-1:0]  RESET_PC    = '0,
    parameter logic [DATA_W-1:0]  HALT_OPCODE = DATA_W'(8'h78)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] Inst_Addr,
    input  logic [DATA_W-1:0] Instruction,
    output logic              fe_valid,
    input  logic              fe_ready,
    output logic [DATA_W-1:0] fe_instr,
    output logic [ADDR_W-1:0] fe_pc,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              halted
);

    localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  count;
    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [DATA_W-1:0] buf_instr [BUF_DEPTH];
    logic [ADDR_W-1:0] buf_pc    [BUF_DEPTH];

    logic              flush;
    logic              do_pop;
    logic              do_push;
    logic              is_halt;
    logic              has_room;
    logic [PTR_W-1:0]  head_nxt;
    logic [CNT_W-1:0]  count_nxt;
    logic [CNT_W-1:0]  remain;
    logic [DATA_W-1:0] head_instr_nxt;
    logic [ADDR_W-1:0] head_pc_nxt;

    assign Inst_Addr = pc;

    // Push/pop decisions and the entry that will sit at the buffer head next cycle
    always_comb begin
        flush          = redirect && (state != S_IDLE);
        do_pop         = fe_valid && fe_ready;
        is_halt        = (Instruction == HALT_OPCODE);
        has_room       = (count < CNT_W'(BUF_DEPTH)) || do_pop;
        do_push        = (state == S_RUN) && !flush && !is_halt && has_room;
        head_nxt       = do_pop ? PTR_W'(head + PTR_W'(1)) : head;
        count_nxt      = CNT_W'(count + CNT_W'(do_push) - CNT_W'(do_pop));
        remain         = CNT_W'(count - CNT_W'(do_pop));
        head_instr_nxt = buf_instr[head_nxt];
        head_pc_nxt    = buf_pc[head_nxt];
        // An empty buffer after the pop means the word being pushed becomes the head
        if (remain == '0) begin
            head_instr_nxt = Instruction;
            head_pc_nxt    = pc;
        end
    end

    // Control FSM, PC, prefetch buffer and registered decode-side outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= S_IDLE;
            pc       <= RESET_PC;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            fe_valid <= 1'b0;
            fe_instr <= '0;
            fe_pc    <= '0;
            halted   <= 1'b0;
            for (int i = 0; i < int'(BUF_DEPTH); i++) begin
                buf_instr[i] <= '0;
                buf_pc[i]    <= '0;
            end
        end else if (flush) begin
            // Redirect wins over everything: drop the buffer and any in-flight word
            state    <= S_RUN;
            pc       <= redirect_pc;
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            fe_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            if (do_push) begin
                buf_instr[tail] <= Instruction;
                buf_pc[tail]    <= pc;
                tail            <= PTR_W'(tail + PTR_W'(1));
                pc              <= ADDR_W'(pc + ADDR_W'(1));
            end
            head     <= head_nxt;
            count    <= count_nxt;
            fe_valid <= (count_nxt != '0);
            if (count_nxt != '0) begin
                fe_instr <= head_instr_nxt;
                fe_pc    <= head_pc_nxt;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (is_halt) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end
                end
                S_HALT: begin
                    state <= S_HALT;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: directed scenarios followed by
// random traffic, compared every cycle against a queue-based reference model.
module tb_inst_fetch_unit;

    logic       clk;
    logic       reset_n;
    logic       start;
    logic [7:0] inst_addr;
    logic [7:0] instruction;
    logic       fe_valid;
    logic       fe_ready;
    logic [7:0] fe_instr;
    logic [7:0] fe_pc;
    logic       redirect;
    logic [7:0] redirect_pc;
    logic       halted;

    logic [7:0] mem [256];

    int n_vec = 0;
    int n_err = 0;

    // reference model: 0 = idle, 1 = fetching, 2 = halted
    int          m_mode;
    logic [7:0]  m_pc;
    logic [15:0] m_q [$];

    inst_fetch_unit dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .Inst_Addr   (inst_addr),
        .Instruction (instruction),
        .fe_valid    (fe_valid),
        .fe_ready    (fe_ready),
        .fe_instr    (fe_instr),
        .fe_pc       (fe_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted)
    );

    assign instruction = mem[inst_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0;
        m_pc   = 8'h00;
        m_q.delete();
    endtask

    // One clock edge of the reference behaviour, using the inputs just driven
    task automatic model_edge();
        logic       pop;
        logic [7:0] w;
        if (m_mode == 0) begin
            if (start) m_mode = 1;
        end else if (redirect) begin
            m_q.delete();
            m_pc   = redirect_pc;
            m_mode = 1;
        end else begin
            pop = (m_q.size() != 0) && fe_ready;
            if (pop) void'(m_q.pop_front());
            if (m_mode == 1) begin
                w = mem[m_pc];
                if (w == 8'h78) begin
                    m_mode = 2;
                end else if (m_q.size() < 2) begin
                    m_q.push_back({m_pc, w});
                    m_pc = m_pc + 8'd1;
                end
            end
        end
    endtask

    task automatic compare();
        logic [15:0] h;
        chk("fe_valid", 32'(fe_valid), 32'(m_q.size() != 0));
        chk("inst_addr", 32'(inst_addr), 32'(m_pc));
        chk("halted", 32'(halted), 32'(m_mode == 2));
        if (m_q.size() != 0) begin
            h = m_q[0];
            chk("fe_instr", 32'(fe_instr), 32'(h[7:0]));
            chk("fe_pc", 32'(fe_pc), 32'(h[15:8]));
        end
    endtask

    task automatic step(input logic st, input logic rdy, input logic rd, input logic [7:0] rpc);
        @(negedge clk);
        start       = st;
        fe_ready    = rdy;
        redirect    = rd;
        redirect_pc = rpc;
        model_edge();
        @(posedge clk);
        #1;
        compare();
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(fe_valid), 32'd0);
        chk({tag, "_halted"}, 32'(halted), 32'd0);
        chk({tag, "_addr"}, 32'(inst_addr), 32'h00);
        chk({tag, "_instr"}, 32'(fe_instr), 32'd0);
        chk({tag, "_pc"}, 32'(fe_pc), 32'd0);
    endtask

    // Asynchronous reset between clock edges, then release
    task automatic mid_reset();
        @(negedge clk);
        #2 reset_n = 1'b0;
        start    = 1'b0;
        redirect = 1'b0;
        #1;
        model_reset();
        check_reset_values("mid_rst");
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic fill_mem_random(input int halt_odds);
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom_range(0, 255));
            if (v == 8'h78) v = 8'h79;
            if ($urandom_range(0, halt_odds - 1) == 0) v = 8'h78;
            mem[i] = v;
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        start       = 1'b0;
        fe_ready    = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 8'h00;
        fill_mem_random(100000);
        for (int i = 0; i < 5; i++) mem[i] = 8'(i + 1);
        mem[5] = 8'h78;
        model_reset();
        #1;
        check_reset_values("rst");
        @(negedge clk);
        reset_n = 1'b1;

        // basic streaming, then halt on mem[5] and drain
        step(1'b1, 1'b1, 1'b0, 8'h00);
        repeat (10) step(1'b0, 1'b1, 1'b0, 8'h00);

        // redirect out of HALT across the address wrap
        step(1'b0, 1'b1, 1'b1, 8'hFE);
        repeat (6) step(1'b0, 1'b1, 1'b0, 8'h00);

        // backpressure: buffer fills, PC stalls, then release
        mid_reset();
        step(1'b1, 1'b0, 1'b0, 8'h00);
        repeat (5) step(1'b0, 1'b0, 1'b0, 8'h00);
        repeat (4) step(1'b0, 1'b1, 1'b0, 8'h00);

        // redirect while the buffer is full and decode is popping
        step(1'b0, 1'b0, 1'b1, 8'h10);
        repeat (3) step(1'b0, 1'b0, 1'b0, 8'h00);
        step(1'b0, 1'b1, 1'b1, 8'h40);
        repeat (5) step(1'b0, 1'b1, 1'b0, 8'h00);

        // random traffic with sparse halt words, redirects and resets
        fill_mem_random(30);
        mid_reset();
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                mid_reset();
            end else begin
                step(($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 9) < 6),
                     ($urandom_range(0, 24) == 0),
                     8'($urandom_range(0, 255)));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
